// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio
// Brief    : M-stage data responder: word RAM plus an MMIO page holding a
//            cycle counter, an LED register and a debug-output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio #(
    parameter int RAM_ADDR_BITS = 8,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] led,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    input  logic        dbg_ready
);

    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_RAM_WORDS = 1 << RAM_ADDR_BITS;

    localparam logic [15:0] c_OFF_CYCLE = 16'h0000;
    localparam logic [15:0] c_OFF_LED   = 16'h0004;
    localparam logic [15:0] c_OFF_TX    = 16'h0008;
    localparam logic [15:0] c_OFF_STAT  = 16'h000C;

    logic [31:0]              r_ram_q [c_RAM_WORDS];
    logic [31:0]              r_fifo_q [FIFO_DEPTH];

    logic [31:0]              r_cycle_q, w_cycle_d;
    logic [31:0]              r_led_q,   w_led_d;
    logic                     r_ovf_q,   w_ovf_d;
    logic [c_CNT_W-1:0]       r_count_q, w_count_d;
    logic [c_PTR_W-1:0]       r_wptr_q,  w_wptr_d;
    logic [c_PTR_W-1:0]       r_rptr_q,  w_rptr_d;

    logic                     w_mmio_sel;
    logic [15:0]              w_off;
    logic [RAM_ADDR_BITS-1:0] w_ram_idx;
    logic                     w_ram_we;
    logic                     w_wr_cycle;
    logic                     w_wr_led;
    logic                     w_wr_tx;
    logic                     w_wr_stat;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [31:0]              w_count_ext;
    logic [3:0]               w_count_field;
    logic                     w_unused;

    // Byte lane bits play no part in decode: every access is a full word.
    assign w_unused   = ^addr[1:0];

    assign w_mmio_sel = (addr[31:16] == 16'hFFFF);
    assign w_off      = {addr[15:2], 2'b00};
    assign w_ram_idx  = addr[RAM_ADDR_BITS+1:2];

    assign w_ram_we   = mem_write && !w_mmio_sel;
    assign w_wr_cycle = mem_write && w_mmio_sel && (w_off == c_OFF_CYCLE);
    assign w_wr_led   = mem_write && w_mmio_sel && (w_off == c_OFF_LED);
    assign w_wr_tx    = mem_write && w_mmio_sel && (w_off == c_OFF_TX);
    assign w_wr_stat  = mem_write && w_mmio_sel && (w_off == c_OFF_STAT);

    assign w_empty    = (r_count_q == '0);
    assign w_full     = (r_count_q == c_CNT_W'(FIFO_DEPTH));
    assign w_pop      = !w_empty && dbg_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_wr_tx && (!w_full || w_pop);
    assign w_drop     = w_wr_tx && w_full && !w_pop;

    assign w_count_ext   = 32'(r_count_q);
    assign w_count_field = (w_count_ext > 32'd15) ? 4'hF : w_count_ext[3:0];

    assign led       = r_led_q;
    assign dbg_valid = !w_empty;
    assign dbg_data  = w_empty ? 32'h0 : r_fifo_q[r_rptr_q];

    always_comb begin
        w_cycle_d = r_cycle_q + 32'd1;
        if (w_wr_cycle) begin
            w_cycle_d = write_data;
        end
        w_led_d = r_led_q;
        if (w_wr_led) begin
            w_led_d = write_data;
        end
        // Set dominates clear when both land in one cycle.
        w_ovf_d = r_ovf_q;
        if (w_wr_stat) begin
            w_ovf_d = 1'b0;
        end
        if (w_drop) begin
            w_ovf_d = 1'b1;
        end
        w_count_d = r_count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        w_wptr_d  = r_wptr_q + c_PTR_W'(w_push);
        w_rptr_d  = r_rptr_q + c_PTR_W'(w_pop);
    end

    always_comb begin
        read_data = 32'h0;
        if (!w_mmio_sel) begin
            read_data = r_ram_q[w_ram_idx];
        end else begin
            case (w_off)
                c_OFF_CYCLE: read_data = r_cycle_q;
                c_OFF_LED:   read_data = r_led_q;
                c_OFF_STAT:  read_data = {25'b0, w_count_field, r_ovf_q, w_full, w_empty};
                default:     read_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_q <= 32'h0;
            r_led_q   <= 32'h0;
            r_ovf_q   <= 1'b0;
            r_count_q <= '0;
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
        end else begin
            r_cycle_q <= w_cycle_d;
            r_led_q   <= w_led_d;
            r_ovf_q   <= w_ovf_d;
            r_count_q <= w_count_d;
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
        end
    end

    // Storage arrays are not reset; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_ram_we) begin
            r_ram_q[w_ram_idx] <= write_data;
        end
        if (!rst && w_push) begin
            r_fifo_q[r_wptr_q] <= write_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio
// Brief    : Self-checking bench for dmem_mmio against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

    localparam logic [31:0] c_CYCLE = 32'hFFFF_0000;
    localparam logic [31:0] c_LED   = 32'hFFFF_0004;
    localparam logic [31:0] c_TX    = 32'hFFFF_0008;
    localparam logic [31:0] c_STAT  = 32'hFFFF_000C;

    logic        clk;
    logic        rst;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] led;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        dbg_ready;

    int n_cmp;
    int n_fail;

    // Reference model state
    logic [31:0] m_ram [256];
    logic [31:0] m_cycle;
    logic [31:0] m_led;
    logic        m_ovf;
    logic [31:0] m_q [$];

    dmem_mmio #(.RAM_ADDR_BITS(8), .FIFO_DEPTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .led        (led),
        .dbg_valid  (dbg_valid),
        .dbg_data   (dbg_data),
        .dbg_ready  (dbg_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cycle = 32'h0;
        m_led   = 32'h0;
        m_ovf   = 1'b0;
        m_q.delete();
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [3:0] cnt;
        if (a[31:16] != 16'hFFFF) return m_ram[a[9:2]];
        cnt = 4'(m_q.size());
        case ({a[15:2], 2'b00})
            16'h0000: return m_cycle;
            16'h0004: return m_led;
            16'h000C: return {25'b0, cnt, m_ovf, (m_q.size() == 8), (m_q.size() == 0)};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic void model_step(input logic we, input logic [31:0] a,
                                       input logic [31:0] wd, input logic rdy);
        bit pop;
        bit was_full;
        pop      = rdy && (m_q.size() != 0);
        was_full = (m_q.size() == 8);
        m_cycle  = m_cycle + 32'd1;
        if (pop) void'(m_q.pop_front());
        if (we && a[31:16] != 16'hFFFF) m_ram[a[9:2]] = wd;
        if (we && a[31:16] == 16'hFFFF) begin
            case ({a[15:2], 2'b00})
                16'h0000: m_cycle = wd;
                16'h0004: m_led = wd;
                16'h0008: if (!was_full || pop) m_q.push_back(wd); else m_ovf = 1'b1;
                16'h000C: m_ovf = 1'b0;
                default: ;
            endcase
        end
    endfunction

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        mem_write  = we;
        addr       = a;
        write_data = wd;
        dbg_ready  = rdy;
        #1;
    endtask

    task automatic tick();
        if (rst) model_reset();
        else model_step(mem_write, addr, write_data, dbg_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (led !== 32'h0) begin n_fail++; $display("FAIL reset_led: got %h want %h", led, 32'h0); end
        n_cmp++; if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dbg_valid); end
        n_cmp++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dbg_data); end
        drive(1'b0, c_STAT, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h1) begin n_fail++; $display("FAIL reset_stat: got %h want %h", read_data, 32'h1); end
    endtask

    task automatic test_cycle();
        logic [31:0] exp [6];
        exp = '{32'd0, 32'd1, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, c_CYCLE, 32'h0, 1'b0);
            n_cmp++; if (read_data !== exp[i]) begin n_fail++; $display("FAIL cycle_run%0d: got %h want %h", i, read_data, exp[i]); end
            if (i < 2) tick();
        end
        drive(1'b1, c_CYCLE, 32'hFFFF_FFFE, 1'b0);
        tick();
        for (int i = 3; i < 6; i++) begin
            drive(1'b0, c_CYCLE | 32'h3, 32'h0, 1'b0);
            n_cmp++; if (read_data !== exp[i]) begin n_fail++; $display("FAIL cycle_wrap%0d: got %h want %h", i, read_data, exp[i]); end
            tick();
        end
    endtask

    task automatic test_ram();
        drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        n_cmp++; if (read_data !== 32'h0 && read_data !== model_read(32'h10)) begin n_fail++; $display("FAIL ram_rdw_old: got %h want %h", read_data, model_read(32'h10)); end
        tick();
        drive(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_load: got %h want DEADBEEF", read_data); end
        drive(1'b0, 32'h0000_0410, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_alias: got %h want DEADBEEF", read_data); end
        drive(1'b0, 32'h0000_0013, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_byteoff: got %h want DEADBEEF", read_data); end
        tick();
    endtask

    task automatic test_led();
        drive(1'b1, c_LED, 32'h0000_00A5, 1'b0);
        tick();
        drive(1'b1, 32'hFFFF_0010, 32'h1234_5678, 1'b0);
        n_cmp++; if (led !== 32'hA5) begin n_fail++; $display("FAIL led_out: got %h want a5", led); end
        n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", read_data); end
        tick();
        drive(1'b0, c_LED, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'hA5) begin n_fail++; $display("FAIL led_read: got %h want a5", read_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (led !== 32'h0) begin n_fail++; $display("FAIL led_reset: got %h want 0", led); end
    endtask

    task automatic test_fifo_overflow();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, c_TX, 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, c_TX, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL tx_read: got %h want 0", read_data); end
        drive(1'b0, c_STAT, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h46) begin n_fail++; $display("FAIL ovf_stat: got %h want 46", read_data); end
        drive(1'b0, c_STAT, 32'h0, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            n_cmp++; if (dbg_valid !== 1'b1 || dbg_data !== 32'(i)) begin n_fail++; $display("FAIL drain%0d: got v=%b d=%h want v=1 d=%h", i, dbg_valid, dbg_data, i); end
            tick();
        end
        n_cmp++; if (dbg_valid !== 1'b0 || dbg_data !== 32'h0) begin n_fail++; $display("FAIL drain_empty: got v=%b d=%h want v=0 d=0", dbg_valid, dbg_data); end
        n_cmp++; if (read_data !== 32'h5) begin n_fail++; $display("FAIL stat_after_drain: got %h want 5", read_data); end
        drive(1'b1, c_STAT, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(1'b0, c_STAT, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h want 1", read_data); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp [8];
        exp = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'h55};
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, c_TX, 32'h10 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, c_TX, 32'h55, 1'b1);
        n_cmp++; if (dbg_data !== 32'h11) begin n_fail++; $display("FAIL ppf_head: got %h want 11", dbg_data); end
        tick();
        drive(1'b0, c_STAT, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h42) begin n_fail++; $display("FAIL ppf_stat: got %h want 42", read_data); end
        drive(1'b0, c_STAT, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (dbg_data !== exp[i]) begin n_fail++; $display("FAIL ppf_drain%0d: got %h want %h", i, dbg_data, exp[i]); end
            tick();
        end
        n_cmp++; if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL ppf_empty: got %b want 0", dbg_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, c_TX, 32'hA0 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, c_LED, 32'h77, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, c_STAT, 32'h0, 1'b0);
        n_cmp++; if (dbg_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", dbg_valid); end
        n_cmp++; if (read_data !== 32'h1) begin n_fail++; $display("FAIL rmid_stat: got %h want 1", read_data); end
        n_cmp++; if (led !== 32'h0) begin n_fail++; $display("FAIL rmid_led: got %h want 0", led); end
        drive(1'b0, c_CYCLE, 32'h0, 1'b0);
        n_cmp++; if (read_data !== 32'h0) begin n_fail++; $display("FAIL rmid_cycle: got %h want 0", read_data); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp_head;
        logic [15:0] offs [5];
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i) << 2, $urandom, 1'b0);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0)
                a = ($urandom & 32'h7FFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            else
                a = {16'hFFFF, offs[$urandom_range(0, 4)] | 16'($urandom_range(0, 3))};
            rst = ($urandom_range(0, 60) == 0);
            drive(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) == 0));
            exp_head = (m_q.size() != 0) ? m_q[0] : 32'h0;
            n_cmp++; if (read_data !== model_read(a)) begin n_fail++; $display("FAIL rnd_read%0d @%h: got %h want %h", n, a, read_data, model_read(a)); end
            n_cmp++; if (dbg_valid !== (m_q.size() != 0) || dbg_data !== exp_head) begin n_fail++; $display("FAIL rnd_fifo%0d: got v=%b d=%h want d=%h", n, dbg_valid, dbg_data, exp_head); end
            n_cmp++; if (led !== m_led) begin n_fail++; $display("FAIL rnd_led%0d: got %h want %h", n, led, m_led); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) m_ram[i] = 32'h0;
        model_reset();
        rst        = 1'b1;
        mem_write  = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        dbg_ready  = 1'b0;
        test_reset();
        test_cycle();
        test_ram();
        test_led();
        test_fifo_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
